// File: rtl/simon_decrypt.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// simon_decrypt
// Iterative Simon 128/128 decryption core (inverse of top_simon).
// Expands the master key forward to k66/k67, then runs 68 inverse rounds
// while regenerating the earlier round keys backwards.
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous, active-high reset
//   start_i  start request, sampled only while idle
//   ct_i     ciphertext, x = [127:64], y = [63:0]
//   k0_i     master key, k1 = [127:64], k0 = [63:0]
//   pt_o     plaintext, held until the next completion
//   busy_o   high during key expansion and decryption
//   done_o   one-cycle pulse when pt_o is updated
// -----------------------------------------------------------------------------
module simon_decrypt (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_i,
    input  logic [127:0] ct_i,
    input  logic [127:0] k0_i,
    output logic [127:0] pt_o,
    output logic         busy_o,
    output logic         done_o
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_KEYEXP = 2'd1;
    localparam logic [1:0] S_DEC    = 2'd2;

    localparam logic [63:0] C_CONST = 64'hFFFF_FFFF_FFFF_FFFC;
    // z2 with z[0] in the MSB position
    localparam logic [61:0] Z2 =
        62'b10101111011100000011010010011000101000010001111110010110110011;

    logic [1:0]   r_state;
    logic [63:0]  r_x;
    logic [63:0]  r_y;
    logic [63:0]  r_klo;
    logic [63:0]  r_khi;
    logic [6:0]   r_cnt;
    logic [127:0] r_pt;
    logic         r_done;

    logic [63:0]  w_fwd;
    logic [63:0]  w_bwd;
    logic [63:0]  w_ynew;

    // z index wraps mod 62
    function automatic logic z_bit(input logic [6:0] idx);
        logic [6:0] m;
        logic [5:0] p;
        m = idx % 7'd62;
        p = 6'd61 - m[5:0];
        return Z2[p];
    endfunction

    function automatic logic [63:0] ror34(input logic [63:0] v);
        return {v[2:0], v[63:3]} ^ {v[3:0], v[63:4]};
    endfunction

    function automatic logic [63:0] round_f(input logic [63:0] v);
        return ({v[62:0], v[63]} & {v[55:0], v[63:56]}) ^ {v[61:0], v[63:62]};
    endfunction

    always_comb begin
        // klo/khi = k[cnt], k[cnt+1] -> k[cnt+2]
        w_fwd  = C_CONST ^ {63'b0, z_bit(r_cnt)} ^ r_klo ^ ror34(r_khi);
        // klo/khi = k[cnt-1], k[cnt] -> k[cnt-2]; meaningless for cnt < 2
        w_bwd  = r_khi ^ C_CONST ^ {63'b0, z_bit(r_cnt - 7'd2)} ^ ror34(r_klo);
        w_ynew = r_x ^ round_f(r_y) ^ r_khi;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_x     <= '0;
            r_y     <= '0;
            r_klo   <= '0;
            r_khi   <= '0;
            r_cnt   <= '0;
            r_pt    <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_x     <= ct_i[127:64];
                        r_y     <= ct_i[63:0];
                        r_klo   <= k0_i[63:0];
                        r_khi   <= k0_i[127:64];
                        r_cnt   <= '0;
                        r_state <= S_KEYEXP;
                    end
                end
                S_KEYEXP: begin
                    r_klo <= r_khi;
                    r_khi <= w_fwd;
                    if (r_cnt == 7'd65) begin
                        r_cnt   <= 7'd67;
                        r_state <= S_DEC;
                    end else begin
                        r_cnt <= r_cnt + 7'd1;
                    end
                end
                S_DEC: begin
                    r_x   <= r_y;
                    r_y   <= w_ynew;
                    r_khi <= r_klo;
                    r_klo <= w_bwd;
                    if (r_cnt == 7'd0) begin
                        r_pt    <= {r_y, w_ynew};
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 7'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign pt_o   = r_pt;
    assign done_o = r_done;
    assign busy_o = (r_state != S_IDLE);

endmodule

// File: tb/tb_simon_decrypt.sv
`timescale 1ns/1ps
// Testbench for simon_decrypt: reference Simon 128/128 model (full key
// schedule array, forward encrypt and inverse decrypt loops) versus the DUT.
module tb_simon_decrypt;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_i;
    logic [127:0] ct_i;
    logic [127:0] k0_i;
    logic [127:0] pt_o;
    logic         busy_o;
    logic         done_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    simon_decrypt dut (
        .clk     (clk),
        .rst     (rst),
        .start_i (start_i),
        .ct_i    (ct_i),
        .k0_i    (k0_i),
        .pt_o    (pt_o),
        .busy_o  (busy_o),
        .done_o  (done_o)
    );

    // ---------------- reference model ----------------
    logic [63:0] m_k [0:67];

    function automatic logic [63:0] rol(input logic [63:0] v, input int n);
        return (v << n) | (v >> (64 - n));
    endfunction

    function automatic logic [63:0] mf(input logic [63:0] v);
        return (rol(v, 1) & rol(v, 8)) ^ rol(v, 2);
    endfunction

    function automatic void expand(input logic [127:0] key);
        logic [61:0] z;
        logic [63:0] zb;
        z = 62'b10101111011100000011010010011000101000010001111110010110110011;
        m_k[0] = key[63:0];
        m_k[1] = key[127:64];
        for (int i = 0; i < 66; i++) begin
            zb = '0;
            zb[0] = z[61 - (i % 62)];
            // ROR3 = ROL61, ROR4 = ROL60
            m_k[i+2] = 64'hFFFF_FFFF_FFFF_FFFC ^ zb ^ m_k[i]
                       ^ rol(m_k[i+1], 61) ^ rol(m_k[i+1], 60);
        end
    endfunction

    function automatic logic [127:0] model_encrypt(input logic [127:0] key, input logic [127:0] pt);
        logic [63:0] x, y, t;
        expand(key);
        x = pt[127:64];
        y = pt[63:0];
        for (int i = 0; i < 68; i++) begin
            t = x;
            x = y ^ mf(x) ^ m_k[i];
            y = t;
        end
        return {x, y};
    endfunction

    function automatic logic [127:0] model_decrypt(input logic [127:0] key, input logic [127:0] ct);
        logic [63:0] x, y, t;
        expand(key);
        x = ct[127:64];
        y = ct[63:0];
        for (int j = 67; j >= 0; j--) begin
            t = y;
            y = x ^ mf(y) ^ m_k[j];
            x = t;
        end
        return {x, y};
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- stimulus helpers ----------------
    // Called just after a rising edge; start is sampled on the next edge (E0).
    task automatic run_op(input logic [127:0] key, input logic [127:0] ct,
                          output logic [127:0] res, output int lat);
        k0_i    = key;
        ct_i    = ct;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        lat = -1;
        for (int n = 1; n <= 300; n++) begin
            @(posedge clk); #1;
            if (done_o) begin
                lat = n;
                break;
            end
        end
        res = pt_o;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; start_i = 1'b0; ct_i = '0; k0_i = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (pt_o !== 128'h0) begin
            failures++; $display("FAIL reset_pt got=%h exp=0", pt_o);
        end
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0) begin
            failures++; $display("FAIL reset_flags busy=%b done=%b exp=0/0", busy_o, done_o);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_known_answer();
        logic [127:0] res; int lat;
        run_op(128'h0f0e0d0c0b0a09080706050403020100,
               128'h49681b1e1e54fe3f65aa832af84e0bbc, res, lat);
        checks++;
        if (res !== 128'h63736564207372656c6c657661727420) begin
            failures++; $display("FAIL kat_pt got=%h exp=63736564207372656c6c657661727420", res);
        end
        checks++;
        if (lat != 134) begin
            failures++; $display("FAIL kat_latency got=%0d exp=134", lat);
        end
    endtask

    task automatic test_round_trip();
        logic [127:0] v, ct, res; int lat;
        v  = 128'h74636364616e69656c31322f32303234;
        ct = model_encrypt(v, v);
        run_op(v, ct, res, lat);
        checks++;
        if (res !== v || lat != 134) begin
            failures++; $display("FAIL round_trip got=%h lat=%0d exp=%h lat=134", res, lat, v);
        end
    endtask

    task automatic test_random();
        logic [127:0] key, pt, ct, res; int lat;
        for (int i = 0; i < 4; i++) begin
            key = rnd128();
            pt  = rnd128();
            ct  = model_encrypt(key, pt);
            run_op(key, ct, res, lat);
            checks++;
            if (res !== pt || lat != 134) begin
                failures++; $display("FAIL random_rt[%0d] got=%h lat=%0d exp=%h", i, res, lat, pt);
            end
        end
        for (int i = 0; i < 2; i++) begin
            key = rnd128();
            ct  = rnd128();
            run_op(key, ct, res, lat);
            checks++;
            if (res !== model_decrypt(key, ct)) begin
                failures++; $display("FAIL random_dec[%0d] got=%h exp=%h", i, res, model_decrypt(key, ct));
            end
        end
    endtask

    task automatic test_zero();
        logic [127:0] res; int lat;
        run_op('0, '0, res, lat);
        checks++;
        if (res !== model_decrypt('0, '0)) begin
            failures++; $display("FAIL zero_pt got=%h exp=%h", res, model_decrypt('0, '0));
        end
        checks++;
        if (model_encrypt('0, res) !== 128'h0) begin
            failures++; $display("FAIL zero_reencrypt got=%h exp=0", model_encrypt('0, res));
        end
    endtask

    task automatic test_busy_lockout();
        logic [127:0] key, pt, ct, exp_pt;
        int lat; logic busy_bad;
        key = rnd128(); pt = rnd128(); ct = model_encrypt(key, pt);
        exp_pt = pt;
        k0_i = key; ct_i = ct; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        lat = -1; busy_bad = 1'b0;
        for (int n = 1; n <= 300; n++) begin
            @(posedge clk); #1;
            if (n == 9) begin
                start_i = 1'b1;
                ct_i    = ~ct;
                k0_i    = ~key;
            end
            if (n == 10) start_i = 1'b0;
            if (done_o) begin
                lat = n;
                break;
            end
            if (busy_o !== 1'b1) busy_bad = 1'b1;
        end
        checks++;
        if (busy_bad) begin
            failures++; $display("FAIL lockout_busy got=dropped exp=high_until_E134");
        end
        checks++;
        if (busy_o !== 1'b0 || lat != 134) begin
            failures++; $display("FAIL lockout_end busy=%b lat=%0d exp=0/134", busy_o, lat);
        end
        checks++;
        if (pt_o !== exp_pt) begin
            failures++; $display("FAIL lockout_pt got=%h exp=%h", pt_o, exp_pt);
        end
        @(posedge clk); #1;
        checks++;
        if (done_o !== 1'b0 || busy_o !== 1'b0) begin
            failures++; $display("FAIL lockout_idle done=%b busy=%b exp=0/0", done_o, busy_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] ka, pa, kb, pb, resa;
        int lat; logic hold_bad;
        ka = rnd128(); pa = rnd128();
        kb = rnd128(); pb = rnd128();
        run_op(ka, model_encrypt(ka, pa), resa, lat);
        checks++;
        if (resa !== pa || lat != 134) begin
            failures++; $display("FAIL b2b_first got=%h lat=%0d exp=%h", resa, lat, pa);
        end
        // still in the done_o cycle: start is taken at the next edge
        k0_i = kb; ct_i = model_encrypt(kb, pb); start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        lat = -1; hold_bad = 1'b0;
        for (int n = 1; n <= 300; n++) begin
            @(posedge clk); #1;
            if (done_o) begin
                lat = n;
                break;
            end
            if (pt_o !== resa) hold_bad = 1'b1;
        end
        checks++;
        if (hold_bad) begin
            failures++; $display("FAIL b2b_hold got=changed exp=%h", resa);
        end
        checks++;
        if (pt_o !== pb || lat != 134) begin
            failures++; $display("FAIL b2b_second got=%h lat=%0d exp=%h lat=134", pt_o, lat, pb);
        end
    endtask

    task automatic test_reset_mid();
        logic [127:0] key, pt, res; int lat;
        key = rnd128(); pt = rnd128();
        k0_i = key; ct_i = model_encrypt(key, pt); start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (70) @(posedge clk);
        #1;
        checks++;
        if (busy_o !== 1'b1) begin
            failures++; $display("FAIL rstmid_busy_before got=%b exp=1", busy_o);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (pt_o !== 128'h0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
            failures++; $display("FAIL rstmid_async pt=%h busy=%b done=%b exp=0", pt_o, busy_o, done_o);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        key = rnd128(); pt = rnd128();
        run_op(key, model_encrypt(key, pt), res, lat);
        checks++;
        if (res !== pt || lat != 134) begin
            failures++; $display("FAIL rstmid_after got=%h lat=%0d exp=%h lat=134", res, lat, pt);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start_i = 1'b0; ct_i = '0; k0_i = '0;
        test_reset();
        test_known_answer();
        test_round_trip();
        test_random();
        test_zero();
        test_busy_lockout();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
